// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the fetch queue entry type and the default reset PC.
package cpu_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; low two address bits are always dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/adder_64bit.sv
// Plain 64-bit adder, wrap-around, no carry out.
module adder_64bit (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  output logic [63:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry circular buffer with push/pop/flush; head is zero whenever the buffer is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter type         T     = fetch_entry_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  T     i_wdata,
  output T     o_head,
  output logic o_empty,
  output logic o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Flush overrides both ports; pop on an empty buffer is ignored.
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~i_flush & ~o_empty;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: every read is gated by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_comb begin
    o_head = '0;
    if (!o_empty) o_head = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, buffers {pc, instr} pairs and hands them to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_plus4;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  fetch_entry_t    w_wr_entry;
  fetch_entry_t    w_head;

  assign imem_addr = r_pc;

  // A full queue still accepts a fetch when decode drains the head in the same cycle.
  assign out_valid = ~w_empty & ~redirect;
  assign w_pop     = out_valid & out_ready;
  assign w_push    = ~redirect & (~w_full | w_pop);

  always_comb begin
    w_wr_entry       = '0;
    w_wr_entry.pc    = r_pc;
    w_wr_entry.instr = imem_instr;
  end

  adder_64bit u_pc_adder (
    .i_a   (r_pc),
    .i_b   (PC_W'(4)),
    .o_sum (w_pc_plus4)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= align_pc(redirect_pc);
    end else if (w_push) begin
      r_pc <= w_pc_plus4;
    end
  end

  fetch_queue #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_wdata (w_wr_entry),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule
